// File: rtl/lfsr_ctrl_pkg.sv
// rtl/lfsr_ctrl_pkg.sv - shared types and constants for the LFSR sequencing controller
package lfsr_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEED    = 2'd1,
        RUN     = 2'd2,
        DELIVER = 2'd3
    } lfsr_ctrl_state_t;

    localparam int PERIOD_CNT_W = 8;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting after the last granted index
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [IDX_W-1:0]   idx_o,
    output logic               valid_o
);

    // Walk candidates from farthest to nearest so the nearest set bit after ptr wins.
    always_comb begin
        int c;
        logic [IDX_W-1:0] ci;
        idx_o   = '0;
        valid_o = 1'b0;
        c       = 0;
        ci      = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            c  = (int'(ptr_i) + k) % NUM_REQ;
            ci = IDX_W'(c);
            if (req_i[ci]) begin
                idx_o   = ci;
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lfsr_ctrl.sv
// rtl/lfsr_ctrl.sv - seeds, steps and shares an LFSR; LFSR_CTRL_PERIOD_CNT_EN adds o_Period_Cnt
module lfsr_ctrl
    import lfsr_ctrl_pkg::*;
#(
    parameter int                  NUM_BITS     = 3,
    parameter int                  NUM_REQ      = 4,
    parameter int                  STEPS        = NUM_BITS,
    parameter logic [NUM_BITS-1:0] DEFAULT_SEED = NUM_BITS'(1)
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst_L,
    input  logic [NUM_REQ-1:0]      i_Req,
    output logic [NUM_REQ-1:0]      o_Gnt,
    output logic [NUM_BITS-1:0]     o_Rand_Data,
    output logic                    o_Rand_DV,
    input  logic                    i_Seed_Req,
    input  logic [NUM_BITS-1:0]     i_Seed_Data,
    output logic                    o_Seed_Ack,
    output logic                    o_LFSR_Enable,
    output logic                    o_LFSR_Seed_DV,
    output logic [NUM_BITS-1:0]     o_LFSR_Seed_Data,
    input  logic [NUM_BITS-1:0]     i_LFSR_Data,
    input  logic                    i_LFSR_Done,
`ifdef LFSR_CTRL_PERIOD_CNT_EN
    output logic [PERIOD_CNT_W-1:0] o_Period_Cnt,
`endif
    output logic                    o_Busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    lfsr_ctrl_state_t     state_q, state_d;
    logic                 init_pending_q, init_pending_d;
    logic [NUM_BITS-1:0]  seed_q, seed_d;
    logic [CNT_W-1:0]     step_q, step_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic                 en_q, en_d;
    logic                 seed_dv_q, seed_dv_d;
    logic                 ack_q, ack_d;
    logic                 dv_q, dv_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic                 busy_q, busy_d;

    logic [IDX_W-1:0]     arb_idx;
    logic                 arb_valid;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_i   (i_Req),
        .ptr_i   (ptr_q),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    // Next state plus the output values that belong to the state being entered.
    always_comb begin
        state_d        = state_q;
        init_pending_d = init_pending_q;
        seed_d         = seed_q;
        step_d         = step_q;
        idx_d          = idx_q;
        ptr_d          = ptr_q;
        en_d           = 1'b0;
        seed_dv_d      = 1'b0;
        ack_d          = 1'b0;
        dv_d           = 1'b0;
        gnt_d          = '0;
        unique case (state_q)
            IDLE: begin
                if (init_pending_q) begin
                    state_d        = SEED;
                    seed_d         = DEFAULT_SEED;
                    init_pending_d = 1'b0;
                    en_d           = 1'b1;
                    seed_dv_d      = 1'b1;
                end else if (i_Seed_Req) begin
                    // All-ones locks an XNOR LFSR, so swap in the default seed.
                    state_d   = SEED;
                    seed_d    = (&i_Seed_Data) ? DEFAULT_SEED : i_Seed_Data;
                    en_d      = 1'b1;
                    seed_dv_d = 1'b1;
                    ack_d     = 1'b1;
                end else if (arb_valid) begin
                    state_d = RUN;
                    idx_d   = arb_idx;
                    step_d  = '0;
                    en_d    = 1'b1;
                end
            end
            SEED: begin
                state_d = IDLE;
            end
            RUN: begin
                if (step_q == CNT_W'(STEPS - 1)) begin
                    state_d = DELIVER;
                    dv_d    = 1'b1;
                    gnt_d   = NUM_REQ'(1) << idx_q;
                end else begin
                    step_d = step_q + CNT_W'(1);
                    en_d   = 1'b1;
                end
            end
            DELIVER: begin
                ptr_d   = idx_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; reset aborts any word in flight.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state_q        <= IDLE;
            init_pending_q <= 1'b1;
            seed_q         <= '0;
            step_q         <= '0;
            idx_q          <= '0;
            ptr_q          <= IDX_W'(NUM_REQ - 1);
            en_q           <= 1'b0;
            seed_dv_q      <= 1'b0;
            ack_q          <= 1'b0;
            dv_q           <= 1'b0;
            gnt_q          <= '0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            init_pending_q <= init_pending_d;
            seed_q         <= seed_d;
            step_q         <= step_d;
            idx_q          <= idx_d;
            ptr_q          <= ptr_d;
            en_q           <= en_d;
            seed_dv_q      <= seed_dv_d;
            ack_q          <= ack_d;
            dv_q           <= dv_d;
            gnt_q          <= gnt_d;
            busy_q         <= busy_d;
        end
    end

    assign o_Gnt            = gnt_q;
    assign o_Rand_DV        = dv_q;
    assign o_Rand_Data      = dv_q ? i_LFSR_Data : '0;
    assign o_Seed_Ack       = ack_q;
    assign o_LFSR_Enable    = en_q;
    assign o_LFSR_Seed_DV   = seed_dv_q;
    assign o_LFSR_Seed_Data = seed_q;
    assign o_Busy           = busy_q;

`ifdef LFSR_CTRL_PERIOD_CNT_EN
    logic [PERIOD_CNT_W-1:0] period_q, period_d;

    // Count LFSR wrap-arounds seen while stepping; saturate, restart on every seed load.
    always_comb begin
        period_d = period_q;
        if (state_q == SEED) begin
            period_d = '0;
        end else if (state_q == RUN && i_LFSR_Done && period_q != '1) begin
            period_d = period_q + PERIOD_CNT_W'(1);
        end
    end

    // Period counter register.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            period_q <= '0;
        end else begin
            period_q <= period_d;
        end
    end

    assign o_Period_Cnt = period_q;
`else
    logic unused_done;
    assign unused_done = i_LFSR_Done;
`endif

endmodule

// File: tb/tb_lfsr_ctrl.sv
// tb/tb_lfsr_ctrl.sv - directed self-checking bench for lfsr_ctrl driving a 3-bit XNOR LFSR
module tb_lfsr_ctrl;

    logic       clk = 1'b0;
    logic       rst_l;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [2:0] rand_data;
    logic       rand_dv;
    logic       seed_req;
    logic [2:0] seed_data;
    logic       seed_ack;
    logic       lfsr_en;
    logic       lfsr_seed_dv;
    logic [2:0] lfsr_seed_data;
    logic [2:0] lfsr_q = 3'b000;
    logic       lfsr_done;
    logic       busy;
`ifdef LFSR_CTRL_PERIOD_CNT_EN
    logic [7:0] period_cnt;
`endif

    int passed = 0;
    int total  = 0;
    int n;

    logic [3:0] exp_gnt  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [2:0] exp_data [5] = '{3'b101, 3'b000, 3'b110, 3'b100, 3'b011};
    int         exp_lat  [5] = '{4, 5, 5, 5, 5};

    always #5 clk = ~clk;

    lfsr_ctrl #(
        .NUM_BITS     (3),
        .NUM_REQ      (4),
        .STEPS        (3),
        .DEFAULT_SEED (3'b001)
    ) dut (
        .i_Clk            (clk),
        .i_Rst_L          (rst_l),
        .i_Req            (req),
        .o_Gnt            (gnt),
        .o_Rand_Data      (rand_data),
        .o_Rand_DV        (rand_dv),
        .i_Seed_Req       (seed_req),
        .i_Seed_Data      (seed_data),
        .o_Seed_Ack       (seed_ack),
        .o_LFSR_Enable    (lfsr_en),
        .o_LFSR_Seed_DV   (lfsr_seed_dv),
        .o_LFSR_Seed_Data (lfsr_seed_data),
        .i_LFSR_Data      (lfsr_q),
        .i_LFSR_Done      (lfsr_done),
`ifdef LFSR_CTRL_PERIOD_CNT_EN
        .o_Period_Cnt     (period_cnt),
`endif
        .o_Busy           (busy)
    );

    // 3-bit LFSR: load seed or shift in XNOR of the top two bits; done when back at the seed.
    always @(posedge clk) begin
        if (lfsr_en) begin
            if (lfsr_seed_dv) lfsr_q <= lfsr_seed_data;
            else              lfsr_q <= {lfsr_q[1:0], ~(lfsr_q[2] ^ lfsr_q[1])};
        end
    end
    assign lfsr_done = (lfsr_q == lfsr_seed_data);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_dv(output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!rand_dv && cycles < 20);
    endtask

    initial begin
        rst_l     = 1'b0;
        req       = 4'b0000;
        seed_req  = 1'b0;
        seed_data = 3'b000;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_en", lfsr_en, 0);
        chk("rst_seed_dv", lfsr_seed_dv, 0);
        chk("rst_dv", rand_dv, 0);
        chk("rst_gnt", gnt, 0);
        chk("rst_data", rand_data, 0);

        // Power-up seed
        rst_l = 1'b1;
        tick();
        chk("init_seed_dv", lfsr_seed_dv, 1);
        chk("init_en", lfsr_en, 1);
        chk("init_seed", lfsr_seed_data, 3'b001);
        chk("init_ack", seed_ack, 0);
        chk("init_busy", busy, 1);
        tick();
        chk("init_idle_seed_dv", lfsr_seed_dv, 0);
        chk("init_idle_busy", busy, 0);

        // Single word to requester 1
        req = 4'b0010;
        tick();
        req = 4'b0000;
        chk("w1_run_en", lfsr_en, 1);
        chk("w1_run_dv", rand_dv, 0);
        tick();
        chk("w1_run2_dv", rand_dv, 0);
        tick();
        chk("w1_run3_dv", rand_dv, 0);
        tick();
        chk("w1_dv", rand_dv, 1);
        chk("w1_gnt", gnt, 4'b0010);
        chk("w1_data", rand_data, 3'b101);
        chk("w1_en", lfsr_en, 0);
        tick();
        chk("w1_dv_pulse", rand_dv, 0);

        // Illegal seed beats a pending word request
        seed_req  = 1'b1;
        seed_data = 3'b111;
        req       = 4'b0001;
        tick();
        seed_req = 1'b0;
        chk("s1_ack", seed_ack, 1);
        chk("s1_seed_dv", lfsr_seed_dv, 1);
        chk("s1_seed", lfsr_seed_data, 3'b001);
        wait_dv(n);
        chk("s1_word_lat", n, 5);
        chk("s1_gnt", gnt, 4'b0001);
        chk("s1_data", rand_data, 3'b101);
        req = 4'b0000;
        tick();

        // Legal host seed
        seed_req  = 1'b1;
        seed_data = 3'b110;
        tick();
        seed_req = 1'b0;
        chk("s2_ack", seed_ack, 1);
        chk("s2_seed", lfsr_seed_data, 3'b110);
        tick();
        chk("s2_ack_pulse", seed_ack, 0);
        req = 4'b0001;
        wait_dv(n);
        chk("s2_word_lat", n, 4);
        chk("s2_gnt", gnt, 4'b0001);
        chk("s2_data", rand_data, 3'b100);
        req = 4'b0000;
        tick();

        // Reset during the second RUN cycle
        req = 4'b0100;
        tick();
        tick();
        rst_l = 1'b0;
        tick();
        req = 4'b0000;
        chk("mr_dv", rand_dv, 0);
        chk("mr_busy", busy, 0);
        chk("mr_en", lfsr_en, 0);
        tick();
        chk("mr_dv2", rand_dv, 0);
        rst_l = 1'b1;
        tick();
        chk("mr_seed_dv", lfsr_seed_dv, 1);
        chk("mr_seed", lfsr_seed_data, 3'b001);
        chk("mr_ack", seed_ack, 0);
        tick();
        chk("mr_idle", busy, 0);

        // All requesters held: round-robin from requester 0
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_dv(n);
            chk($sformatf("rr%0d_lat", i), n, exp_lat[i]);
            chk($sformatf("rr%0d_gnt", i), gnt, exp_gnt[i]);
            chk($sformatf("rr%0d_data", i), rand_data, exp_data[i]);
        end
        req = 4'b0000;
        tick();

`ifdef LFSR_CTRL_PERIOD_CNT_EN
        // Seven words of three steps cover the 7-state period three times
        seed_req  = 1'b1;
        seed_data = 3'b001;
        tick();
        seed_req = 1'b0;
        tick();
        chk("pc_cleared", period_cnt, 0);
        req = 4'b0001;
        for (int i = 0; i < 7; i++) wait_dv(n);
        chk("pc_lat", n, 5);
        chk("pc_count", period_cnt, 3);
        req = 4'b0000;
        tick();
        seed_req  = 1'b1;
        seed_data = 3'b110;
        tick();
        seed_req = 1'b0;
        tick();
        chk("pc_reseed", period_cnt, 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/lfsr_ctrl.md
# lfsr_ctrl

Sequencing and sharing controller for the `LFSR` block. It seeds the LFSR at reset and on host request, then runs it for a fixed number of shift steps per random word. It grants each resulting word to one of `NUM_REQ` requesters under round-robin arbitration. It sits between the LFSR instance and its consumers and is the only driver of the LFSR's enable and seed inputs.

## Interface
Parameters:
- `NUM_BITS`, 3: LFSR width; also the width of the seed and random words.
- `NUM_REQ`, 4: number of requesters, from 2 to 8.
- `STEPS`, `NUM_BITS`: LFSR shifts per delivered word, at least 1.
- `DEFAULT_SEED`, 1: seed loaded after reset and substituted for an illegal seed. Must not be all-ones.

Ports (one clock, `i_Clk`; reset `i_Rst_L` is synchronous, active-low):
- `i_Clk` in 1: clock, rising edge.
- `i_Rst_L` in 1: synchronous active-low reset.
- `i_Req` in `NUM_REQ`: per-requester level request. Held until that requester's grant.
- `o_Gnt` out `NUM_REQ`: one-hot; high for one cycle together with `o_Rand_DV`.
- `o_Rand_Data` out `NUM_BITS`: random word, valid while `o_Rand_DV` is high.
- `o_Rand_DV` out 1: one-cycle data-valid pulse.
- `i_Seed_Req` in 1: host reseed request. Held until `o_Seed_Ack`.
- `i_Seed_Data` in `NUM_BITS`: requested seed.
- `o_Seed_Ack` out 1: one-cycle pulse in the cycle the host seed is loaded.
- `o_LFSR_Enable` out 1: drives the LFSR's `i_Enable`.
- `o_LFSR_Seed_DV` out 1: drives the LFSR's `i_Seed_DV`.
- `o_LFSR_Seed_Data` out `NUM_BITS`: drives the LFSR's `i_Seed_Data`.
- `i_LFSR_Data` in `NUM_BITS`: from the LFSR's `o_LFSR_Data`.
- `i_LFSR_Done` in 1: from the LFSR's `o_LFSR_Done`; pulses when the LFSR returns to its seed.
- `o_Busy` out 1: high whenever the state is not IDLE.

## Operation
- FSM states:
  - IDLE: all LFSR controls low.
  - SEED: `o_LFSR_Enable`=1, `o_LFSR_Seed_DV`=1.
  - RUN: `o_LFSR_Enable`=1, `o_LFSR_Seed_DV`=0.
  - DELIVER: LFSR controls low; `o_Rand_DV`=1; `o_Gnt`=one-hot(selected index); `o_Rand_Data`=`i_LFSR_Data`.
- All outputs are decoded from registered state only.
- Reset: the state goes to IDLE and the `init_pending` flag is set.
  - Round-robin pointer (last granted index) is set to `NUM_REQ-1`, so requester 0 wins first.
  - Step counter, seed register and period counter are cleared.
  - Every output is 0 while `i_Rst_L` is low.
- IDLE transitions, in priority order:
  1. `init_pending`: go to SEED with `DEFAULT_SEED`. No `o_Seed_Ack`. Clear `init_pending`.
  2. `i_Seed_Req`: latch the seed (`DEFAULT_SEED` if `i_Seed_Data` is all-ones) and go to SEED. `o_Seed_Ack` pulses in SEED.
  3. Any `i_Req`: select the first set bit searching upward from pointer+1 with wrap. Latch the index, clear the step counter, go to RUN.
- SEED lasts one cycle, then returns to IDLE.
- RUN lasts exactly `STEPS` cycles (counter 0..`STEPS`-1), then goes to DELIVER.
- DELIVER lasts one cycle. It updates the pointer to the delivered index and returns to IDLE.
- A grant is committed once RUN is entered. Deasserting `i_Req` during RUN still produces DELIVER to that index.
- Requests are sampled only in IDLE. A seed request arriving during RUN waits for IDLE and then beats any pending word request.

## Timing
- Word latency: `i_Req` sampled at edge T (IDLE) gives `o_Rand_DV`/`o_Gnt` high during the cycle after edge T+`STEPS`, i.e. `STEPS`+1 cycles after sampling.
- Throughput: one word per `STEPS`+2 cycles with continuous requests.
- Seed latency: `i_Seed_Req` sampled at edge T gives `o_LFSR_Seed_DV` and `o_Seed_Ack` high during cycle T..T+1.
- After reset release, the first edge enters SEED. `o_LFSR_Seed_DV` is high for exactly one cycle with `DEFAULT_SEED`.
- Reset mid-RUN or mid-DELIVER: the operation is aborted, no further `o_Rand_DV`, and outputs are 0 from the next cycle.

## Configuration
- `LFSR_CTRL_PERIOD_CNT_EN` defined: adds output `o_Period_Cnt` (8 bits).
  - Increments on `i_LFSR_Done` sampled while the state is RUN.
  - Saturates at 255.
  - Cleared by reset and by every SEED cycle.
- `LFSR_CTRL_PERIOD_CNT_EN` undefined: no port, no counter logic. All other behaviour is identical.

## Structure
- Package `lfsr_ctrl_pkg`:
  - State enum `lfsr_ctrl_state_t` (IDLE, SEED, RUN, DELIVER).
  - `PERIOD_CNT_W`=8.
- Sub-module `rr_arbiter`: inputs request vector and last-grant pointer; outputs selected index and a valid flag. Purely combinational, parameterised by `NUM_REQ`.
- The FSM, step counter, seed register and period counter live in `lfsr_ctrl`.

## Test plan
Bench uses NUM_BITS=3, NUM_REQ=4, STEPS=3, DEFAULT_SEED=3'b001, and a real `LFSR` instance.
- Reset release, no requests -> one cycle of `o_LFSR_Seed_DV`=1 and `o_LFSR_Enable`=1 with seed 3'b001; `o_Seed_Ack` stays 0; then idle.
- `i_Req`=4'b0010 for one IDLE edge -> `o_Gnt`=4'b0010 and `o_Rand_DV`=1 exactly 4 cycles later; `o_Rand_Data` matches a 3-step model of the LFSR from seed 001.
- `i_Req`=4'b1111 held -> grants 0001, 0010, 0100, 1000, 0001, spaced 5 cycles apart.
- `i_Seed_Req` with 3'b111 while `i_Req`=4'b0001 -> SEED first with 3'b001 and `o_Seed_Ack`=1, then the word; with 3'b110 -> 3'b110 is loaded.
- `i_Rst_L` low in the 2nd RUN cycle -> no `o_Rand_DV`; after release the seed sequence repeats and requester 0 wins first.
- With `LFSR_CTRL_PERIOD_CNT_EN`: `i_Req[0]` held for 7 words (21 steps, period 7) -> `o_Period_Cnt`=3; a subsequent host seed -> 0.
